// File: rtl/position_sequencer.sv
// Steps a 2-bit position code (home=00, mid=01, front=10) one slot at a time toward
// a commanded target. Each slot is held for STEP_CYCLES clocks.
module position_sequencer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_target,
    input  logic       abort,
    output logic [1:0] pos,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic {IDLE, MOVE} state_t;

    localparam logic [7:0] RELOAD = 8'(STEP_CYCLES - 1);

    state_t     state, state_nx;
    logic [1:0] tgt, tgt_nx, pos_nx, step_pos;
    logic       up, up_nx;
    logic [7:0] cnt, cnt_nx;
    logic       busy_nx, done_nx, err_nx;

    assign cmd_ready = (state == IDLE);

    // Targets are never 11, so stepping toward one can never reach 11.
    assign step_pos = up ? pos + 2'd1 : pos - 2'd1;

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        tgt_nx   = tgt;
        up_nx    = up;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_target == 2'b11) begin
                        err_nx = 1'b1;
                    end else if (cmd_target == pos) begin
                        done_nx = 1'b1;
                    end else begin
                        tgt_nx   = cmd_target;
                        up_nx    = (cmd_target > pos);
                        cnt_nx   = RELOAD;
                        busy_nx  = 1'b1;
                        state_nx = MOVE;
                    end
                end
            end
            MOVE: begin
                if (abort) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else begin
                    pos_nx = step_pos;
                    if (step_pos == tgt) begin
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = RELOAD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos   <= 2'b00;
            tgt   <= 2'b00;
            up    <= 1'b0;
            cnt   <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            pos   <= pos_nx;
            tgt   <= tgt_nx;
            up    <= up_nx;
            cnt   <= cnt_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

endmodule

// File: tb/tb_position_sequencer.sv
// Directed, table-driven bench for position_sequencer: a STEP_CYCLES=4 instance
// walked cycle by cycle from a vector table, plus a STEP_CYCLES=1 instance.
module tb_position_sequencer;

    typedef struct {
        logic       cv;
        logic [1:0] tgt;
        logic       ab;
        logic       rs;
        logic [1:0] pos;
        logic       busy;
        logic       done;
        logic       err;
        logic       rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, abort;
    logic [1:0] cmd_target;
    logic       cmd_ready, busy, done, err;
    logic [1:0] pos;

    logic       rst1, cmd_valid1, abort1;
    logic [1:0] cmd_target1;
    logic       cmd_ready1, busy1, done1, err1;
    logic [1:0] pos1;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    position_sequencer #(.STEP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .abort(abort), .pos(pos), .busy(busy),
        .done(done), .err(err)
    );

    position_sequencer #(.STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_target(cmd_target1), .abort(abort1), .pos(pos1), .busy(busy1),
        .done(done1), .err(err1)
    );

    task automatic add(input logic cv, input logic [1:0] t, input logic ab, input logic rs,
                       input logic [1:0] p, input logic b, input logic d, input logic e,
                       input logic r);
        vec_t v;
        v.cv = cv; v.tgt = t; v.ab = ab; v.rs = rs;
        v.pos = p; v.busy = b; v.done = d; v.err = e; v.rdy = r;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Outputs are checked 1 time unit after the edge that consumed the inputs.
    task automatic tick1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_target = 2'b00; abort = 1'b0;
        rst1 = 1'b1; cmd_valid1 = 1'b0; cmd_target1 = 2'b00; abort1 = 1'b0;

        //   cv tgt ab rs | pos b d e rdy
        add(0, 0, 0, 1,   0, 0, 0, 0, 1);           // 0 reset
        repeat (3) add(0, 0, 0, 0, 0, 0, 0, 0, 1);  // 1-3 idle hold
        add(1, 2, 0, 0,   0, 1, 0, 0, 0);           // 4 E: home->front
        repeat (3) add(0, 0, 0, 0, 0, 1, 0, 0, 0);  // 5-7
        add(0, 0, 0, 0,   1, 1, 0, 0, 0);           // 8 E+4
        repeat (3) add(0, 0, 0, 0, 1, 1, 0, 0, 0);  // 9-11
        add(0, 0, 0, 0,   2, 0, 1, 0, 1);           // 12 E+8 done
        add(0, 0, 0, 0,   2, 0, 0, 0, 1);           // 13
        add(1, 1, 0, 0,   2, 1, 0, 0, 0);           // 14 front->mid
        repeat (3) add(0, 0, 0, 0, 2, 1, 0, 0, 0);  // 15-17
        add(0, 0, 0, 0,   1, 0, 1, 0, 1);           // 18 done
        add(0, 0, 0, 0,   1, 0, 0, 0, 1);           // 19
        add(1, 0, 0, 0,   1, 1, 0, 0, 0);           // 20 mid->home
        repeat (3) add(1, 2, 0, 0, 1, 1, 0, 0, 0);  // 21-23 held cmd ignored
        add(1, 2, 0, 0,   0, 0, 1, 0, 1);           // 24 done; cmd still ignored
        add(1, 2, 0, 0,   0, 1, 0, 0, 0);           // 25 E: held cmd accepted
        repeat (3) add(0, 0, 0, 0, 0, 1, 0, 0, 0);  // 26-28
        add(0, 0, 0, 0,   1, 1, 0, 0, 0);           // 29 E+4
        add(0, 0, 1, 0,   1, 0, 0, 0, 1);           // 30 E+5 abort
        add(0, 0, 0, 0,   1, 0, 0, 0, 1);           // 31
        add(1, 2, 0, 0,   1, 1, 0, 0, 0);           // 32 mid->front after abort
        repeat (3) add(0, 0, 0, 0, 1, 1, 0, 0, 0);  // 33-35
        add(0, 0, 0, 0,   2, 0, 1, 0, 1);           // 36 done
        add(0, 0, 0, 0,   2, 0, 0, 0, 1);           // 37
        add(0, 0, 1, 0,   2, 0, 0, 0, 1);           // 38 abort in idle
        add(1, 3, 0, 0,   2, 0, 0, 1, 1);           // 39 illegal target
        add(0, 0, 0, 0,   2, 0, 0, 0, 1);           // 40
        add(1, 2, 0, 0,   2, 0, 1, 0, 1);           // 41 zero-step move
        add(0, 0, 0, 0,   2, 0, 0, 0, 1);           // 42
        add(1, 0, 0, 0,   2, 1, 0, 0, 0);           // 43 front->home
        repeat (3) add(0, 0, 0, 0, 2, 1, 0, 0, 0);  // 44-46
        add(0, 0, 0, 0,   1, 1, 0, 0, 0);           // 47
        repeat (3) add(0, 0, 0, 0, 1, 1, 0, 0, 0);  // 48-50
        add(0, 0, 0, 0,   0, 0, 1, 0, 1);           // 51 done
        add(0, 0, 0, 0,   0, 0, 0, 0, 1);           // 52
        add(1, 3, 0, 0,   0, 0, 0, 1, 1);           // 53 illegal at home
        add(0, 0, 0, 0,   0, 0, 0, 0, 1);           // 54
        add(1, 0, 0, 0,   0, 0, 1, 0, 1);           // 55 zero-step at home
        add(0, 0, 0, 0,   0, 0, 0, 0, 1);           // 56
        add(1, 1, 0, 0,   0, 1, 0, 0, 0);           // 57 home->mid
        repeat (3) add(0, 0, 0, 0, 0, 1, 0, 0, 0);  // 58-60
        add(0, 0, 1, 0,   0, 0, 0, 0, 1);           // 61 abort on final step wins
        add(0, 0, 0, 0,   0, 0, 0, 0, 1);           // 62
        add(1, 2, 0, 0,   0, 1, 0, 0, 0);           // 63 E: home->front
        repeat (3) add(0, 0, 0, 0, 0, 1, 0, 0, 0);  // 64-66
        add(0, 0, 0, 0,   1, 1, 0, 0, 0);           // 67 E+4
        add(0, 0, 0, 0,   1, 1, 0, 0, 0);           // 68 E+5
        add(1, 1, 1, 1,   0, 0, 0, 0, 1);           // 69 E+6 reset wins
        add(0, 0, 0, 0,   0, 0, 0, 0, 1);           // 70

        for (int i = 0; i < vecs.size(); i++) begin
            cmd_valid  = vecs[i].cv;
            cmd_target = vecs[i].tgt;
            abort      = vecs[i].ab;
            rst        = vecs[i].rs;
            if (i == 1) rst1 = 1'b0;
            tick1();
            chk("pos",       i, int'(pos),       int'(vecs[i].pos));
            chk("busy",      i, int'(busy),      int'(vecs[i].busy));
            chk("done",      i, int'(done),      int'(vecs[i].done));
            chk("err",       i, int'(err),       int'(vecs[i].err));
            chk("cmd_ready", i, int'(cmd_ready), int'(vecs[i].rdy));
        end

        // STEP_CYCLES=1: home->front in two cycles.
        cmd_valid1 = 1'b1; cmd_target1 = 2'b10;
        tick1();
        chk("s1_pos_E",  0, int'(pos1),  0);
        chk("s1_busy_E", 0, int'(busy1), 1);
        cmd_valid1 = 1'b0; cmd_target1 = 2'b00;
        tick1();
        chk("s1_pos_E1",  1, int'(pos1),  1);
        chk("s1_busy_E1", 1, int'(busy1), 1);
        tick1();
        chk("s1_pos_E2",  2, int'(pos1),       2);
        chk("s1_done_E2", 2, int'(done1),      1);
        chk("s1_rdy_E2",  2, int'(cmd_ready1), 1);
        tick1();
        chk("s1_done_E3", 3, int'(done1), 0);
        chk("s1_pos_E3",  3, int'(pos1),  2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/position_sequencer.md
Name: position_sequencer

Overview:
- Drives the 2-bit position code into the position converter (home=00, mid=01, front=10).
- Accepts move commands from game logic over a valid/ready handshake.
- Steps the position one slot at a time toward the target, holding each intermediate slot for a programmable dwell time.
- Reports busy, completion and illegal-target errors.

Parameters:
- STEP_CYCLES, 4, clock cycles between consecutive position steps (legal range 1..255; step counter is 8 bits).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (combinational: high iff state==IDLE).
- cmd_target  input  2  requested position code (00/01/10; 11 illegal).
- abort  input  1  cancel move in progress.
- pos  output  2  current position code, registered; feeds converter input.
- busy  output  1  registered; high while in MOVE.
- done  output  1  registered; one-cycle pulse on successful completion.
- err  output  1  registered; one-cycle pulse on illegal target.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: pos=00, busy=0, done=0, err=0, state=IDLE, step counter=0. cmd_ready is therefore 1 in the first cycle after reset.
- States: IDLE, MOVE.
- done and err default to 0 every cycle unless set below.
- Acceptance: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
- On accepted command, evaluated at the same edge:
  - cmd_target==11: err=1 next cycle; stay IDLE; pos unchanged.
  - cmd_target==pos: done=1 next cycle; stay IDLE; busy stays 0 (zero-step move).
  - Otherwise: latch target and direction (up if target>pos); state=MOVE; busy=1; counter=STEP_CYCLES-1.
- MOVE, each edge, in priority order:
  1. abort=1: state=IDLE, busy=0, pos holds, no done.
  2. counter!=0: counter decrements.
  3. counter==0: pos steps ±1 toward target.
     - If the new pos equals target: state=IDLE, busy=0, done=1.
     - Otherwise: counter reloads to STEP_CYCLES-1.
- Timing, with acceptance at edge E:
  - First pos change at edge E+STEP_CYCLES.
  - home→front: pos=01 at E+S, pos=10 at E+2S; done high for the single cycle after E+2S.
  - cmd_ready returns high in that same cycle, so a new command may be accepted back-to-back at edge E+2S+1.
- cmd_valid while cmd_ready=0 is ignored; requesters hold cmd_valid/cmd_target until accepted.
- cmd_target is sampled only at acceptance; later changes have no effect.
- abort in IDLE: ignored.
- abort coinciding with the final step: abort wins; pos does not step; no done.
- pos only ever changes by one code per step; it never passes through 11.
- rst mid-move: next edge returns to the reset values (pos=00) regardless of state, abort or cmd_valid.
- STEP_CYCLES=1: one step per cycle; home→front completes in 2 cycles.

Test Plan:
- Reset → pos=00, busy=0, done=0, err=0, cmd_ready=1; hold 3 cycles, no change.
- STEP_CYCLES=4, accept target=10 from 00 at edge E → busy=1 from E; pos=01 at E+4; pos=10 at E+8; done=1 exactly one cycle; busy=0 and cmd_ready=1 in that cycle.
- From pos=10, target=01 → pos=01 at E+4, done pulse, no other pos change; then cmd_valid held during a move → not accepted until cmd_ready=1.
- Target=11 from pos=00 → err=1 one cycle; done=0; busy never asserts; pos stays 00. Target=00 at pos=00 → done=1 next cycle, busy stays 0.
- Home→front, abort at E+5 (after pos=01) → state IDLE next cycle; pos stays 01; no done; busy=0; next command from 01 executes normally.
- rst asserted at E+6 during home→front → pos=00, busy=0, done=0 next cycle. STEP_CYCLES=1 home→front → pos=01 at E+1, pos=10 at E+2.
